// File: rtl/rf_ctrl_pkg.sv
// Shared register-file controller types and default geometry.
// Imported by the write arbiter and anything else that talks to reg_file.
package rf_ctrl_pkg;

  localparam int RF_W     = 8;
  localparam int RF_AW    = 4;
  localparam int RF_DEPTH = 8;

  typedef enum logic {
    ARB   = 1'b0,
    CLEAR = 1'b1
  } rf_ctrl_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant plus its own priority pointer.
// The search starts just after the last granted requester and wraps.
module rr_arbiter #(
  parameter int NREQ = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt
);

  localparam int PW = (NREQ > 2) ? 2 : 1;

  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] ptr_nxt;

  // NOTE: every variable written here gets a default first, otherwise paths
  // that skip an assignment would infer a latch.
  always_comb begin
    int   idx;
    logic found;
    gnt     = '0;
    ptr_nxt = rr_ptr;
    found   = 1'b0;
    idx     = 0;
    if (en) begin
      for (int k = 1; k <= NREQ; k++) begin
        idx = (int'(rr_ptr) + k) % NREQ;
        if (!found && req[idx]) begin
          gnt[idx] = 1'b1;
          ptr_nxt  = PW'(idx);
          found    = 1'b1;
        end
      end
    end
  end

  // Reset pointer to the last requester so requester 0 wins first.
  always_ff @(posedge clk) begin
    if (!rst_n) rr_ptr <= PW'(NREQ - 1);
    else        rr_ptr <= ptr_nxt;
  end

endmodule

// File: rtl/reg_file_wr_arbiter.sv
// Shares the reg_file write port between NREQ requesters (round-robin) and
// runs a zero-fill sequence over addresses 0..DEPTH-1 on clr_start.
module reg_file_wr_arbiter
  import rf_ctrl_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int W     = RF_W,
  parameter int AW    = RF_AW,
  parameter int DEPTH = RF_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr_start,
  output logic                     clr_busy,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0][AW-1:0]  req_addr,
  input  logic [NREQ-1:0][W-1:0]   req_data,
  output logic [NREQ-1:0]          gnt,
  output logic                     rf_wr_en,
  output logic [AW-1:0]            rf_addr,
  output logic [W-1:0]             rf_dat,
  output logic                     addr_err
);

  // One extra bit so DEPTH == 2**AW compares cleanly without wrap handling.
  localparam int CW = AW + 1;

  rf_ctrl_state_t  state, state_nxt;
  logic [CW-1:0]   clr_cnt;
  logic            arb_en;
  logic            granted;
  logic            addr_bad;
  logic            clr_last;
  logic [AW-1:0]   sel_addr;
  logic [W-1:0]    sel_data;

  // clr_start pre-empts arbitration in the same cycle; no grants in reset.
  assign arb_en   = rst_n && (state == ARB) && !clr_start;
  assign clr_last = (clr_cnt == CW'(DEPTH - 1));
  assign clr_busy = (state == CLEAR);
  assign granted  = |gnt;
  assign addr_bad = ({1'b0, sel_addr} >= CW'(DEPTH));

  rr_arbiter #(.NREQ(NREQ)) u_rr_arbiter (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (arb_en),
    .req   (req),
    .gnt   (gnt)
  );

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        sel_addr = req_addr[i];
        sel_data = req_data[i];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ARB:     if (clr_start) state_nxt = CLEAR;
      CLEAR:   if (clr_last)  state_nxt = ARB;
      default: state_nxt = ARB;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ARB;
      clr_cnt  <= '0;
      rf_wr_en <= 1'b0;
      rf_addr  <= '0;
      rf_dat   <= '0;
      addr_err <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        CLEAR: begin
          rf_wr_en <= 1'b1;
          rf_addr  <= clr_cnt[AW-1:0];
          rf_dat   <= '0;
          addr_err <= 1'b0;
          clr_cnt  <= clr_cnt + 1'b1;
        end
        default: begin
          if (clr_start) clr_cnt <= '0;
          if (granted) begin
            rf_wr_en <= !addr_bad;
            rf_addr  <= sel_addr;
            rf_dat   <= sel_data;
            addr_err <= addr_bad;
          end else begin
            rf_wr_en <= 1'b0;
            addr_err <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_file_wr_arbiter.sv
// Directed bench: arbiter in front of a behavioural register file, checked
// through the register contents and the arbiter's own outputs.
module tb_reg_file_wr_arbiter;

  localparam int NREQ  = 2;
  localparam int W     = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 8;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    clr_start;
  logic                    clr_busy;
  logic [NREQ-1:0]         req;
  logic [NREQ-1:0][AW-1:0] req_addr;
  logic [NREQ-1:0][W-1:0]  req_data;
  logic [NREQ-1:0]         gnt;
  logic                    rf_wr_en;
  logic [AW-1:0]           rf_addr;
  logic [W-1:0]            rf_dat;
  logic                    addr_err;

  logic [W-1:0] mem [16];

  int checks   = 0;
  int failures = 0;

  logic [AW-1:0] a0 [2] = '{4'd0, 4'd1};
  logic [W-1:0]  d0 [2] = '{8'h10, 8'h11};
  logic [AW-1:0] a1 [2] = '{4'd2, 4'd3};
  logic [W-1:0]  d1 [2] = '{8'h20, 8'h21};

  always #5 clk = ~clk;

  // Register file model: write port only, contents survive reset.
  always @(posedge clk) if (rf_wr_en) mem[rf_addr] <= rf_dat;

  reg_file_wr_arbiter #(.NREQ(NREQ), .W(W), .AW(AW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_start (clr_start),
    .clr_busy  (clr_busy),
    .req       (req),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .gnt       (gnt),
    .rf_wr_en  (rf_wr_en),
    .rf_addr   (rf_addr),
    .rf_dat    (rf_dat),
    .addr_err  (addr_err)
  );

  task automatic load_ff();
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      req         = 2'b01;
      req_addr[0] = AW'(i);
      req_data[0] = 8'hFF;
    end
    @(negedge clk);
    req = 2'b00;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clr_start = 1'b0; req = 2'b11; req_addr = '0; req_data = '0;
    @(negedge clk); @(negedge clk); #1;
    checks++;
    if (gnt !== 2'b00) begin
      failures++; $display("FAIL reset_gnt: got %b expected 00", gnt);
    end
    req = 2'b00; rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if ({rf_wr_en, gnt, clr_busy, addr_err} !== 5'b0 || rf_addr !== 4'd0 || rf_dat !== 8'd0) begin
        failures++;
        $display("FAIL idle_c%0d: got wr=%b gnt=%b busy=%b err=%b addr=%h dat=%h expected all 0",
                 c, rf_wr_en, gnt, clr_busy, addr_err, rf_addr, rf_dat);
      end
    end
  endtask

  task automatic test_single();
    @(negedge clk);
    req = 2'b01; req_addr[0] = 4'd3; req_data[0] = 8'hA5; #1;
    checks++;
    if (gnt !== 2'b01) begin failures++; $display("FAIL single_gnt: got %b expected 01", gnt); end
    @(negedge clk);
    req = 2'b00;
    checks++;
    if (rf_wr_en !== 1'b1 || rf_addr !== 4'd3 || rf_dat !== 8'hA5 || addr_err !== 1'b0) begin
      failures++;
      $display("FAIL single_out: got wr=%b addr=%h dat=%h err=%b expected 1 3 a5 0",
               rf_wr_en, rf_addr, rf_dat, addr_err);
    end
    @(negedge clk);
    checks++;
    if (mem[3] !== 8'hA5 || rf_wr_en !== 1'b0) begin
      failures++; $display("FAIL single_mem: got reg3=%h wr=%b expected a5 0", mem[3], rf_wr_en);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0]    exp_g;
    logic [AW-1:0] exp_a;
    logic [W-1:0]  exp_d;
    int            k0;
    exp_a = '0; exp_d = '0;
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (c > 0) begin
        checks++;
        if (rf_wr_en !== 1'b1 || rf_addr !== exp_a || rf_dat !== exp_d) begin
          failures++;
          $display("FAIL rr_out_c%0d: got wr=%b addr=%h dat=%h expected 1 %h %h",
                   c, rf_wr_en, rf_addr, rf_dat, exp_a, exp_d);
        end
      end
      k0 = (c + 1) / 2;
      if (k0 > 1) k0 = 1;
      req = 2'b11;
      req_addr[0] = a0[k0];   req_data[0] = d0[k0];
      req_addr[1] = a1[c/2];  req_data[1] = d1[c/2];
      #1;
      exp_g = (c % 2 == 0) ? 2'b01 : 2'b10;
      exp_a = (c % 2 == 0) ? a0[c/2] : a1[c/2];
      exp_d = (c % 2 == 0) ? d0[c/2] : d1[c/2];
      checks++;
      if (gnt !== exp_g) begin
        failures++; $display("FAIL rr_gnt_c%0d: got %b expected %b", c, gnt, exp_g);
      end
    end
    @(negedge clk);
    req = 2'b00;
    checks++;
    if (rf_wr_en !== 1'b1 || rf_addr !== exp_a || rf_dat !== exp_d) begin
      failures++;
      $display("FAIL rr_out_last: got wr=%b addr=%h dat=%h expected 1 %h %h",
               rf_wr_en, rf_addr, rf_dat, exp_a, exp_d);
    end
    @(negedge clk);
    checks++;
    if (mem[0] !== 8'h10 || mem[1] !== 8'h11 || mem[2] !== 8'h20 || mem[3] !== 8'h21) begin
      failures++;
      $display("FAIL rr_mem: got %h %h %h %h expected 10 11 20 21", mem[0], mem[1], mem[2], mem[3]);
    end
  endtask

  task automatic test_clear();
    load_ff();
    req = 2'b10; req_addr[1] = 4'd5; req_data[1] = 8'h5A; clr_start = 1'b1; #1;
    checks++;
    if (gnt !== 2'b00) begin failures++; $display("FAIL clr_start_gnt: got %b expected 00", gnt); end
    for (int j = 0; j < DEPTH; j++) begin
      @(negedge clk);
      clr_start = (j == 3);
      #1;
      checks++;
      if (clr_busy !== 1'b1 || gnt !== 2'b00) begin
        failures++; $display("FAIL clr_busy_c%0d: got busy=%b gnt=%b expected 1 00", j, clr_busy, gnt);
      end
      if (j > 0) begin
        checks++;
        if (rf_wr_en !== 1'b1 || rf_addr !== AW'(j - 1) || rf_dat !== 8'h00) begin
          failures++;
          $display("FAIL clr_wr_c%0d: got wr=%b addr=%h dat=%h expected 1 %h 00",
                   j, rf_wr_en, rf_addr, rf_dat, AW'(j - 1));
        end
      end
    end
    @(negedge clk);
    clr_start = 1'b0; #1;
    checks++;
    if (clr_busy !== 1'b0 || gnt !== 2'b10 || rf_wr_en !== 1'b1 || rf_addr !== 4'd7 || rf_dat !== 8'h00) begin
      failures++;
      $display("FAIL clr_end: got busy=%b gnt=%b wr=%b addr=%h dat=%h expected 0 10 1 7 00",
               clr_busy, gnt, rf_wr_en, rf_addr, rf_dat);
    end
    @(negedge clk);
    req = 2'b00;
    for (int r = 0; r < DEPTH; r++) begin
      checks++;
      if (mem[r] !== 8'h00) begin failures++; $display("FAIL clr_mem%0d: got %h expected 00", r, mem[r]); end
    end
    @(negedge clk);
    checks++;
    if (mem[5] !== 8'h5A) begin failures++; $display("FAIL clr_req1: got reg5=%h expected 5a", mem[5]); end
  endtask

  task automatic test_addr_err();
    @(negedge clk);
    req = 2'b01; req_addr[0] = 4'd9; req_data[0] = 8'h77; #1;
    checks++;
    if (gnt !== 2'b01) begin failures++; $display("FAIL err_gnt: got %b expected 01", gnt); end
    @(negedge clk);
    req = 2'b00;
    checks++;
    if (addr_err !== 1'b1 || rf_wr_en !== 1'b0 || rf_addr !== 4'd9) begin
      failures++;
      $display("FAIL err_pulse: got err=%b wr=%b addr=%h expected 1 0 9", addr_err, rf_wr_en, rf_addr);
    end
    @(negedge clk);
    checks++;
    if (addr_err !== 1'b0 || mem[9] === 8'h77) begin
      failures++; $display("FAIL err_end: got err=%b reg9=%h expected 0 and reg9 untouched", addr_err, mem[9]);
    end
    for (int r = 0; r < DEPTH; r++) begin
      checks++;
      if (mem[r] !== ((r == 5) ? 8'h5A : 8'h00)) begin
        failures++; $display("FAIL err_mem%0d: got %h expected %h", r, mem[r], (r == 5) ? 8'h5A : 8'h00);
      end
    end
  endtask

  task automatic test_reset_mid_clear();
    load_ff();
    clr_start = 1'b1;
    @(negedge clk); clr_start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (rf_wr_en !== 1'b1 || rf_addr !== 4'd2) begin
      failures++; $display("FAIL rstclr_pre: got wr=%b addr=%h expected 1 2", rf_wr_en, rf_addr);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if (clr_busy !== 1'b0 || rf_wr_en !== 1'b0 || rf_addr !== 4'd0 || rf_dat !== 8'd0 || addr_err !== 1'b0) begin
      failures++;
      $display("FAIL rstclr_out: got busy=%b wr=%b addr=%h dat=%h err=%b expected all 0",
               clr_busy, rf_wr_en, rf_addr, rf_dat, addr_err);
    end
    @(negedge clk);
    req = 2'b01; req_addr[0] = 4'd6; req_data[0] = 8'h3C; #1;
    checks++;
    if (gnt !== 2'b01 || clr_busy !== 1'b0) begin
      failures++; $display("FAIL rstclr_arb: got gnt=%b busy=%b expected 01 0", gnt, clr_busy);
    end
    for (int r = 0; r < DEPTH; r++) begin
      checks++;
      if (mem[r] !== ((r < 3) ? 8'h00 : 8'hFF)) begin
        failures++; $display("FAIL rstclr_mem%0d: got %h expected %h", r, mem[r], (r < 3) ? 8'h00 : 8'hFF);
      end
    end
    @(negedge clk);
    req = 2'b00;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_clear();
    test_addr_err();
    test_reset_mid_clear();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
